// File: rtl/mdr_mem_port.sv
// Memory data register with handshaked sub-word memory access; MDR_TIMEOUT_EN adds a wait-state timeout.
// Latency: register load 1 cycle, access done/q 1 cycle after mem_ready; holds strobes until mem_ready.
module mdr_mem_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    MDRin,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [LANE_BITS-1:0]    addr_lo,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  input  logic [DATA_WIDTH-1:0]   Mdatain,
  input  logic                    mem_ready,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   Mdataout,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_FULL = 2'b10;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 32 || LANE_BITS != $clog2(DATA_WIDTH / 8)
      || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mdr_mem_port: inconsistent DATA_WIDTH/LANE_BITS/TIMEOUT_CYCLES");
  end

  logic [1:0]            state;
  logic [1:0]            lat_size;
  logic                  lat_sext;
  logic [LANE_BITS-1:0]  lat_lo;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [NB-1:0]         wr_be;

`ifdef MDR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;
  assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Alignment is judged on the live request fields, before anything is latched.
  assign misaligned = (size == 2'b11)
                    || (size == SZ_HALF && addr_lo[0])
                    || (size == SZ_FULL && addr_lo != '0);

  assign mem_rd = (state == RD_WAIT);
  assign mem_wr = (state == WR_WAIT);
  assign busy   = (state != IDLE);

  assign rd_shift = Mdatain >> {lat_lo, 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    wr_dat = q;
    wr_be  = '1;
    case (lat_size)
      SZ_BYTE: begin
        rd_ext = {{(DATA_WIDTH-8){lat_sext & rd_shift[7]}}, rd_shift[7:0]};
        wr_dat = {NB{q[7:0]}};
        wr_be  = {{(NB-1){1'b0}}, 1'b1} << lat_lo;
      end
      SZ_HALF: begin
        rd_ext = {{(DATA_WIDTH-16){lat_sext & rd_shift[15]}}, rd_shift[15:0]};
        wr_dat = {(NB/2){q[15:0]}};
        wr_be  = {{(NB-2){1'b0}}, 2'b11} << lat_lo;
      end
      default: begin
        rd_ext = rd_shift;
        wr_dat = q;
        wr_be  = '1;
      end
    endcase
  end

  assign mem_be   = mem_wr ? wr_be  : '0;
  assign Mdataout = mem_wr ? wr_dat : '0;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      q        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      lat_size <= '0;
      lat_sext <= 1'b0;
      lat_lo   <= '0;
`ifdef MDR_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Read || Write) begin
            if (misaligned) begin
              err <= 1'b1;
            end else begin
              state    <= Read ? RD_WAIT : WR_WAIT;
              lat_size <= size;
              lat_sext <= sign_ext;
              lat_lo   <= addr_lo;
`ifdef MDR_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end else if (MDRin) begin
            q <= BusMuxOut;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ready) begin
            if (state == RD_WAIT) q <= rd_ext;
            done  <= 1'b1;
            state <= IDLE;
`ifdef MDR_TIMEOUT_EN
          end else if (wait_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed self-checking bench for mdr_mem_port (32-bit, 4 lanes).
module tb_mdr_mem_port;

  logic        clock = 1'b0;
  logic        clear;
  logic        MDRin;
  logic        Read;
  logic        Write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  addr_lo;
  logic [31:0] BusMuxOut;
  logic [31:0] Mdatain;
  logic        mem_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] Mdataout;
  logic [31:0] q;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  mdr_mem_port #(.DATA_WIDTH(32), .LANE_BITS(2), .TIMEOUT_CYCLES(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr_lo   (addr_lo),
    .BusMuxOut (BusMuxOut),
    .Mdatain   (Mdatain),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_be    (mem_be),
    .Mdataout  (Mdataout),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    size = 2'b00; sign_ext = 1'b0; addr_lo = 2'd0;
    BusMuxOut = '0; Mdatain = '0; mem_ready = 1'b0;

    // Reset
    tick; tick;
    chk("rst_q", q, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_dout", Mdataout, 32'h0);
    chk("rst_pulses", {30'b0, done, err}, 32'h0);

    // Register load
    clear = 1'b0; MDRin = 1'b1; BusMuxOut = 32'hDEADBEEF;
    tick;
    chk("load_q", q, 32'hDEADBEEF);
    MDRin = 1'b0;

    // Sign-extended byte read, lane 2, ready after 3 wait cycles
    Read = 1'b1; size = 2'b00; addr_lo = 2'd2; sign_ext = 1'b1; Mdatain = 32'h12F45678;
    tick;
    Read = 1'b0;
    chk("brd_rd_c1", {31'b0, mem_rd}, 32'h1);
    chk("brd_busy", {31'b0, busy}, 32'h1);
    tick;
    chk("brd_rd_c2", {31'b0, mem_rd}, 32'h1);
    tick;
    chk("brd_rd_c3", {31'b0, mem_rd}, 32'h1);
    chk("brd_q_hold", q, 32'hDEADBEEF);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("brd_q", q, 32'hFFFFFFF4);
    chk("brd_done", {31'b0, done}, 32'h1);
    chk("brd_rd_off", {31'b0, mem_rd}, 32'h0);
    tick;
    chk("brd_done_once", {31'b0, done}, 32'h0);

    // Zero-extended halfword read, lane 2, minimum latency
    Read = 1'b1; size = 2'b01; addr_lo = 2'd2; sign_ext = 1'b0; Mdatain = 32'h80010000;
    tick;
    Read = 1'b0; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("hrd_q", q, 32'h00008001);
    chk("hrd_done", {31'b0, done}, 32'h1);

    // Sign-extended halfword read, lane 0
    Read = 1'b1; size = 2'b01; addr_lo = 2'd0; sign_ext = 1'b1; Mdatain = 32'h00009234;
    tick;
    Read = 1'b0; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("hrd_sx_q", q, 32'hFFFF9234);

    // Halfword write of 0x0000ABCD at lane 2
    MDRin = 1'b1; BusMuxOut = 32'h0000ABCD;
    tick;
    MDRin = 1'b0;
    Write = 1'b1; size = 2'b01; addr_lo = 2'd2;
    tick;
    Write = 1'b0;
    chk("hwr_wr", {31'b0, mem_wr}, 32'h1);
    chk("hwr_rd", {31'b0, mem_rd}, 32'h0);
    chk("hwr_dout", Mdataout, 32'hABCDABCD);
    chk("hwr_be", {28'b0, mem_be}, 32'hC);
    tick;
    chk("hwr_wr_hold", {31'b0, mem_wr}, 32'h1);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("hwr_done", {31'b0, done}, 32'h1);
    chk("hwr_wr_off", {31'b0, mem_wr}, 32'h0);
    chk("hwr_be_off", {28'b0, mem_be}, 32'h0);
    chk("hwr_q", q, 32'h0000ABCD);

    // Byte write at lane 1
    Write = 1'b1; size = 2'b00; addr_lo = 2'd1;
    tick;
    Write = 1'b0;
    chk("bwr_dout", Mdataout, 32'hCDCDCDCD);
    chk("bwr_be", {28'b0, mem_be}, 32'h2);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("bwr_done", {31'b0, done}, 32'h1);

    // Misaligned full-width read
    Read = 1'b1; size = 2'b10; addr_lo = 2'd1;
    tick;
    Read = 1'b0;
    chk("mis_err", {31'b0, err}, 32'h1);
    chk("mis_rd", {31'b0, mem_rd}, 32'h0);
    chk("mis_busy", {31'b0, busy}, 32'h0);
    chk("mis_done", {31'b0, done}, 32'h0);
    chk("mis_q", q, 32'h0000ABCD);
    tick;
    chk("mis_err_once", {31'b0, err}, 32'h0);

    // Reserved size write
    Write = 1'b1; size = 2'b11; addr_lo = 2'd0;
    tick;
    Write = 1'b0;
    chk("rsv_err", {31'b0, err}, 32'h1);
    chk("rsv_wr", {31'b0, mem_wr}, 32'h0);

    // mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("idle_rdy_done", {31'b0, done}, 32'h0);

    // MDRin together with Read is ignored
    Read = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h11111111; size = 2'b10; addr_lo = 2'd0;
    tick;
    Read = 1'b0;
    chk("rd_mdr_q", q, 32'h0000ABCD);
    // Inputs while busy are ignored
    Write = 1'b1;
    tick;
    chk("busy_mdr_q", q, 32'h0000ABCD);
    chk("busy_still_rd", {30'b0, mem_rd, mem_wr}, 32'h2);
    // Clear mid-access
    clear = 1'b1; Write = 1'b0; MDRin = 1'b0;
    tick;
    clear = 1'b0;
    chk("clr_q", q, 32'h0);
    chk("clr_rd", {31'b0, mem_rd}, 32'h0);
    chk("clr_busy", {31'b0, busy}, 32'h0);
    chk("clr_done", {31'b0, done}, 32'h0);
    tick;
    chk("clr_done_after", {31'b0, done}, 32'h0);

    // Wait-state limit
    MDRin = 1'b1; BusMuxOut = 32'h5A5A5A5A;
    tick;
    MDRin = 1'b0;
    Read = 1'b1; size = 2'b10; addr_lo = 2'd0;
    tick;
    Read = 1'b0;
`ifdef MDR_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick;
    chk("to_busy_c15", {31'b0, busy}, 32'h1);
    chk("to_err_early", {31'b0, err}, 32'h0);
    tick;
    chk("to_err", {31'b0, err}, 32'h1);
    chk("to_busy", {31'b0, busy}, 32'h0);
    chk("to_done", {31'b0, done}, 32'h0);
    chk("to_q", q, 32'h5A5A5A5A);
`else
    for (int i = 0; i < 99; i++) tick;
    chk("nto_busy", {31'b0, busy}, 32'h1);
    chk("nto_err", {31'b0, err}, 32'h0);
    chk("nto_q", q, 32'h5A5A5A5A);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("nto_clr_busy", {31'b0, busy}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
- Parametrised memory data register with a handshaked memory interface.
- Generalises the single-cycle MDR in three ways: configurable width, sub-word (byte/halfword) loads and stores with lane steering and optional sign extension, and a wait-state state machine that holds the access until memory asserts ready.
- Sits between the CPU internal bus (BusMuxOut) and the memory subsystem; q drives the bus-mux MDR input.

Parameters:
- DATA_WIDTH, 32, register/bus width in bits; multiple of 8, at least 32.
- LANE_BITS, 2, byte-offset width; must equal log2(DATA_WIDTH/8).
- TIMEOUT_CYCLES, 16, wait-state limit; used only with MDR_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-high reset.
- MDRin  in  1  load BusMuxOut into q; honoured in IDLE only.
- Read  in  1  start memory read; sampled in IDLE.
- Write  in  1  start memory write of q; sampled in IDLE.
- size  in  2  access size: 00 byte, 01 halfword, 10 full width, 11 reserved.
- sign_ext  in  1  on reads, 1 sign-extends sub-word data, 0 zero-extends.
- addr_lo  in  LANE_BITS  byte offset of the access, from MAR low bits.
- BusMuxOut  in  DATA_WIDTH  internal bus.
- Mdatain  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  memory completes the current access.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_be  out  DATA_WIDTH/8  byte enables.
- Mdataout  out  DATA_WIDTH  write data to memory.
- q  out  DATA_WIDTH  stored value.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.

Behaviour:
- **States:** IDLE, RD_WAIT, WR_WAIT.
  - mem_rd = (state==RD_WAIT).
  - mem_wr = (state==WR_WAIT).
  - busy = (state!=IDLE).
- **Latched access fields:** size, sign_ext and addr_lo are latched on the edge that leaves IDLE. mem_be and lane extraction use the latched values.
- **clear:** at any state, on the edge, sets q=0, state=IDLE, done=0, err=0 and latched fields = 0. Strobes drop in the following cycle. An access in flight is abandoned and no done is raised.
- **IDLE priority:** Read > Write > MDRin.
  - Read → RD_WAIT.
  - Write → WR_WAIT.
  - MDRin alone → q <= BusMuxOut (full width, no extension).
  - MDRin together with Read or Write is ignored.
- **Alignment check on leaving IDLE:**
  - Misaligned or reserved means: halfword with addr_lo[0]=1, full width with addr_lo≠0, or size=11.
  - A misaligned/reserved access does not leave IDLE: err=1 for one cycle, no strobe, q unchanged.
- **RD_WAIT:** on the edge with mem_ready=1:
  - Extract the lane selected by addr_lo: byte = bits [8*addr_lo +: 8]; halfword = [8*addr_lo +: 16].
  - Extend to DATA_WIDTH per sign_ext and write to q.
  - done=1 the next cycle; state=IDLE.
  - Minimum latency: Read at edge 0, mem_ready in cycle 1, q valid and done high in cycle 2.
- **WR_WAIT:**
  - Mdataout carries q's low byte replicated to all lanes (byte access), q's low halfword replicated (halfword), or q (full width).
  - mem_be is one-hot at lane addr_lo (byte), two bits starting at addr_lo (halfword), or all ones (full width). mem_be is 0 outside WR_WAIT.
  - On mem_ready: done=1 next cycle, state=IDLE, q unchanged.
- **While busy:** MDRin, Read and Write are ignored. mem_ready in IDLE is ignored.
- **Pulses:** done and err are never high together. Both are registered and reset to 0.
- **Reset values:** q=0, mem_rd=0, mem_wr=0, mem_be=0, Mdataout=0, busy=0, done=0, err=0.

Optional Feature:
- Macro: MDR_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle.
  - If mem_ready is not seen within TIMEOUT_CYCLES cycles: return to IDLE, err=1 for one cycle, no done, q unchanged.
  - mem_ready on the same edge the limit is reached counts as success.
- **Undefined:** waits indefinitely. err reports only misaligned/reserved requests. No counter logic is present.

Test Plan:
- **Reset, then register load:** clear, then MDRin=1, BusMuxOut=0xDEADBEEF → q=0 during reset; q=0xDEADBEEF one cycle after the load.
- **Sign-extended byte read:** Read, size=00, addr_lo=2, sign_ext=1; Mdatain=0x12F45678 with mem_ready after 3 wait cycles → mem_rd high 3+ cycles, q=0xFFFFFFF4, done pulses once.
- **Halfword write:** q=0x0000ABCD; Write, size=01, addr_lo=2 → Mdataout=0xABCDABCD, mem_be=1100, mem_wr held until mem_ready, q unchanged.
- **Misaligned request:** Read, size=10, addr_lo=1 → err one cycle, mem_rd never asserted, busy=0.
- **Clear mid-access and ignored inputs:** clear asserted in RD_WAIT → q=0, mem_rd low the next cycle, no done. MDRin/Write pulses while busy change nothing.
- **Timeout (MDR_TIMEOUT_EN, TIMEOUT_CYCLES=16):** Read with mem_ready held low → err after 16 wait cycles, state IDLE, q unchanged. Without the macro, still busy at cycle 100.
